// File: rtl/flash_pkg.sv
// Shared types and width helpers for the LED flash driver and its neighbours.
package flash_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ON   = 2'd1,
    GAP  = 2'd2
  } state_t;

  // Down-counter width: must hold max(hold, gap) - 1, at least one bit.
  function automatic int unsigned cnt_width(input int unsigned hold_cycles,
                                            input int unsigned gap_cycles);
    int unsigned m;
    m = (hold_cycles > gap_cycles) ? hold_cycles : gap_cycles;
    return (m < 2) ? 1 : $clog2(m);
  endfunction

  // Pending-counter width: must hold 0..max_pending inclusive.
  function automatic int unsigned pend_width(input int unsigned max_pending);
    return (max_pending < 1) ? 1 : $clog2(max_pending + 1);
  endfunction

endpackage

// File: rtl/rise_detect.sv
// Rising-edge detector: one-cycle pulse on each low-to-high transition of in.
module rise_detect (
  input  logic clock,
  input  logic reset,
  input  logic in,
  output logic out
);

  logic pulse_q;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      pulse_q <= 1'b0;
    end else begin
      pulse_q <= in;
    end
  end

  assign out = in & ~pulse_q;

endmodule

// File: rtl/pulse_flash_driver.sv
// Turns single-cycle events into fixed-length LED flashes separated by a forced
// off-gap, queueing events that arrive while a flash is in progress.
module pulse_flash_driver
  import flash_pkg::*;
#(
  parameter int unsigned HOLD_CYCLES = 25_000_000,
  parameter int unsigned GAP_CYCLES  = 12_500_000,
  parameter int unsigned MAX_PENDING = 7
) (
  input  logic                                 clock,
  input  logic                                 reset,
  input  logic                                 pulse_in,
  output logic                                 led,
  output logic                                 busy,
  output logic [pend_width(MAX_PENDING)-1:0]   pending,
  output logic                                 overflow
);

  localparam int unsigned CW = cnt_width(HOLD_CYCLES, GAP_CYCLES);
  localparam int unsigned PW = pend_width(MAX_PENDING);

  localparam logic [CW-1:0] HOLD_LOAD = CW'(HOLD_CYCLES - 1);
  localparam logic [CW-1:0] GAP_LOAD  = CW'(GAP_CYCLES - 1);
  localparam logic [PW-1:0] PEND_MAX  = PW'(MAX_PENDING);

  state_t        state;
  logic [CW-1:0] cnt;
  logic          ev;

  rise_detect u_rise_detect (
    .clock (clock),
    .reset (reset),
    .in    (pulse_in),
    .out   (ev)
  );

  // FSM, down-counter, pending queue and sticky overflow in one register block.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      cnt      <= '0;
      pending  <= '0;
      overflow <= 1'b0;
      led      <= 1'b0;
      busy     <= 1'b0;
    end else begin
      led  <= (state == ON);
      busy <= (state != IDLE);

      case (state)
        IDLE: begin
          if (ev) begin
            cnt   <= HOLD_LOAD;
            state <= ON;
          end
        end

        ON: begin
          if (ev) begin
            if (pending == PEND_MAX) overflow <= 1'b1;
            else                     pending  <= pending + PW'(1);
          end
          if (cnt == '0) begin
            cnt   <= GAP_LOAD;
            state <= GAP;
          end else begin
            cnt <= cnt - CW'(1);
          end
        end

        GAP: begin
          if (cnt != '0) begin
            cnt <= cnt - CW'(1);
            if (ev) begin
              if (pending == PEND_MAX) overflow <= 1'b1;
              else                     pending  <= pending + PW'(1);
            end
          end else if (ev) begin
            // Same-cycle event restarts directly; the queue is left untouched.
            cnt   <= HOLD_LOAD;
            state <= ON;
          end else if (pending != '0) begin
            cnt     <= HOLD_LOAD;
            state   <= ON;
            pending <= pending - PW'(1);
          end else begin
            state <= IDLE;
          end
        end

        default: begin
          state <= IDLE;
          cnt   <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pulse_flash_driver.sv
// Directed bench for pulse_flash_driver with HOLD=4, GAP=2, MAX_PENDING=3.
module tb_pulse_flash_driver;

  logic       clock = 1'b0;
  logic       reset;
  logic       pulse_in;
  logic       led;
  logic       busy;
  logic [1:0] pending;
  logic       overflow;

  int checks   = 0;
  int failures = 0;

  always #5 clock = ~clock;

  pulse_flash_driver #(
    .HOLD_CYCLES (4),
    .GAP_CYCLES  (2),
    .MAX_PENDING (3)
  ) dut (
    .clock    (clock),
    .reset    (reset),
    .pulse_in (pulse_in),
    .led      (led),
    .busy     (busy),
    .pending  (pending),
    .overflow (overflow)
  );

  typedef struct {
    logic       p;
    logic       led;
    logic       busy;
    logic [1:0] pend;
    logic       ovf;
  } vec_t;

  vec_t vq[$];

  logic       led_h  [0:63];
  logic       busy_h [0:63];
  logic [1:0] pend_h [0:63];
  logic       ovf_h  [0:63];

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic add(input logic p, input logic l, input logic b,
                     input logic [1:0] pd, input logic o);
    vec_t v;
    v.p = p; v.led = l; v.busy = b; v.pend = pd; v.ovf = o;
    vq.push_back(v);
  endtask

  // Drive pat[i] before edge i and record outputs just after each edge.
  task automatic run(input logic [63:0] pat, input int n);
    for (int i = 0; i < n; i++) begin
      pulse_in = pat[i];
      @(posedge clock);
      #1;
      led_h[i]  = led;
      busy_h[i] = busy;
      pend_h[i] = pending;
      ovf_h[i]  = overflow;
    end
    pulse_in = 1'b0;
  endtask

  // Count flashes in the recorded trace and check every on/off run length.
  task automatic check_flashes(input string nm, input int n, input int exp_flashes);
    int   flashes = 0;
    int   bad     = 0;
    int   hirun   = 0;
    int   lorun   = 0;
    logic prev    = 1'b0;
    for (int i = 0; i < n; i++) begin
      if (led_h[i] && !prev) begin
        flashes++;
        if (flashes > 1 && lorun != 2) bad++;
        hirun = 1;
      end else if (led_h[i]) begin
        hirun++;
      end else if (prev) begin
        if (hirun != 4) bad++;
        lorun = 1;
      end else begin
        lorun++;
      end
      prev = led_h[i];
    end
    if (prev) bad++;
    chk({nm, "_flash_count"}, flashes, exp_flashes);
    chk({nm, "_run_lengths_bad"}, bad, 0);
  endtask

  initial begin
    int pmax;

    reset    = 1'b1;
    pulse_in = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    chk("reset_led", led, 0);
    chk("reset_busy", busy, 0);
    chk("reset_pending", pending, 0);
    chk("reset_overflow", overflow, 0);
    reset = 1'b0;

    // Single flash, then a restart on the final gap cycle with nothing queued.
    add(1, 0, 0, 0, 0);
    for (int i = 0; i < 4; i++) add(0, 1, 1, 0, 0);
    add(0, 0, 1, 0, 0);
    add(0, 0, 1, 0, 0);
    add(0, 0, 0, 0, 0);
    add(0, 0, 0, 0, 0);
    add(1, 0, 0, 0, 0);
    for (int i = 0; i < 4; i++) add(0, 1, 1, 0, 0);
    add(0, 0, 1, 0, 0);
    add(1, 0, 1, 0, 0);
    for (int i = 0; i < 4; i++) add(0, 1, 1, 0, 0);
    add(0, 0, 1, 0, 0);
    add(0, 0, 1, 0, 0);
    add(0, 0, 0, 0, 0);

    foreach (vq[k]) begin
      pulse_in = vq[k].p;
      @(posedge clock);
      #1;
      chk($sformatf("vec%0d_led", k), led, vq[k].led);
      chk($sformatf("vec%0d_busy", k), busy, vq[k].busy);
      chk($sformatf("vec%0d_pending", k), pending, vq[k].pend);
      chk($sformatf("vec%0d_overflow", k), overflow, vq[k].ovf);
    end
    pulse_in = 1'b0;

    // Level held for 20 cycles is a single event.
    run(64'h0000_0000_000F_FFFF, 32);
    check_flashes("held", 32, 1);
    pmax = 0;
    for (int i = 0; i < 32; i++) if (int'(pend_h[i]) > pmax) pmax = int'(pend_h[i]);
    chk("held_pending_max", pmax, 0);
    chk("held_busy_end", busy_h[31], 0);

    // Queued events replay as separate flashes, one consumed per gap exit.
    run(64'h115, 30);
    check_flashes("queue", 30, 4);
    chk("queue_pend_e4", pend_h[4], 2);
    chk("queue_pend_e6", pend_h[6], 1);
    chk("queue_pend_e8", pend_h[8], 2);
    chk("queue_pend_e12", pend_h[12], 1);
    chk("queue_pend_e18", pend_h[18], 0);
    chk("queue_busy_e24", busy_h[24], 1);
    chk("queue_busy_e25", busy_h[25], 0);
    chk("queue_ovf_end", ovf_h[29], 0);

    // Event on final gap cycle while queue is full: net pending unchanged, no overflow.
    run(64'h1515, 40);
    check_flashes("fullsim", 40, 6);
    chk("fullsim_pend_e10", pend_h[10], 3);
    chk("fullsim_pend_e12", pend_h[12], 3);
    chk("fullsim_ovf_e12", ovf_h[12], 0);
    chk("fullsim_pend_e18", pend_h[18], 2);
    chk("fullsim_busy_e36", busy_h[36], 1);
    chk("fullsim_busy_e37", busy_h[37], 0);
    chk("fullsim_ovf_end", ovf_h[39], 0);

    // Saturation: an event with a full queue is dropped and overflow sticks.
    run(64'h1_4515, 40);
    check_flashes("sat", 40, 6);
    chk("sat_pend_e14", pend_h[14], 3);
    chk("sat_ovf_e14", ovf_h[14], 0);
    chk("sat_pend_e16", pend_h[16], 3);
    chk("sat_ovf_e16", ovf_h[16], 1);
    chk("sat_pend_e18", pend_h[18], 2);
    chk("sat_busy_end", busy_h[39], 0);
    chk("sat_ovf_end", ovf_h[39], 1);

    // Asynchronous reset mid-flash with two events queued.
    run(64'h115, 9);
    chk("rst_pre_led", led_h[8], 1);
    chk("rst_pre_pending", pend_h[8], 2);
    chk("rst_pre_overflow", ovf_h[8], 1);
    #2;
    reset = 1'b1;
    #1;
    chk("rst_async_led", led, 0);
    chk("rst_async_busy", busy, 0);
    chk("rst_async_pending", pending, 0);
    chk("rst_async_overflow", overflow, 0);
    repeat (2) @(posedge clock);
    #1;
    reset = 1'b0;
    run(64'h1, 12);
    check_flashes("post_rst", 12, 1);
    chk("post_rst_busy_e6", busy_h[6], 1);
    chk("post_rst_busy_e7", busy_h[7], 0);
    chk("post_rst_pending_e3", pend_h[3], 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
